// File: rtl/uart_rx_if.sv
// Serial receive bus: the line input plus the received-byte outputs and status strobes.
interface uart_rx_if;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_busy;

    // Line driver / byte consumer side
    modport master (
        output rx,
        input  rx_data,
        input  rx_valid,
        input  rx_frame_err,
        input  rx_busy
    );

    // Receiver side
    modport slave (
        input  rx,
        output rx_data,
        output rx_valid,
        output rx_frame_err,
        output rx_busy
    );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 8N1, LSB first, mid-bit sampling on a two-flop synchronised line.
// A stop bit sampled low reports a framing error and parks in BREAK until the
// line returns high, so a held-low line is never decoded as a stream of 0x00.
module uart_rx #(
    parameter int unsigned ClkFreq  = 10_000_000,
    parameter int unsigned BaudRate = 115200
) (
    input  logic     clk,
    input  logic     reset,
    uart_rx_if.slave bus
);

    localparam int unsigned BaudsPerBit = ClkFreq / BaudRate;
    localparam int unsigned HalfBit     = BaudsPerBit / 2;
    localparam int unsigned CntW        = $clog2(BaudsPerBit + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    logic            r_sync1;
    logic            r_rx_s;
    state_t          r_state;
    logic [CntW-1:0] r_cnt;
    logic [3:0]      r_bit_idx;
    logic [7:0]      r_shift;
    logic [7:0]      r_data;
    logic            r_valid;
    logic            r_frame_err;
    logic            r_busy;

    logic            w_half_hit;
    logic            w_bit_hit;

    assign w_half_hit = (r_cnt == CntW'(HalfBit - 1));
    assign w_bit_hit  = (r_cnt == CntW'(BaudsPerBit - 1));

    // Two-flop synchroniser for the asynchronous line; idles high
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
        end else begin
            r_sync1 <= bus.rx;
            r_rx_s  <= r_sync1;
        end
    end

    // Frame FSM with baud counter, shift register and registered strobes/busy
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_cnt       <= r_cnt + CntW'(1);

            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (!r_rx_s) begin
                        r_state <= S_START;
                        r_busy  <= 1'b1;
                    end
                end

                S_START: begin
                    if (w_half_hit) begin
                        r_cnt <= '0;
                        if (!r_rx_s) begin
                            r_state   <= S_DATA;
                            r_bit_idx <= '0;
                        end else begin
                            // Start bit did not survive to mid-bit: treat as a glitch
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end

                S_DATA: begin
                    if (w_bit_hit) begin
                        r_cnt     <= '0;
                        r_shift   <= {r_rx_s, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 4'd1;
                        if (r_bit_idx == 4'd7) begin
                            r_state <= S_STOP;
                        end
                    end
                end

                S_STOP: begin
                    if (w_bit_hit) begin
                        r_cnt <= '0;
                        if (r_rx_s) begin
                            r_data  <= r_shift;
                            r_valid <= 1'b1;
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= S_BREAK;
                        end
                    end
                end

                S_BREAK: begin
                    r_cnt <= '0;
                    if (r_rx_s) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                default: begin
                    r_cnt   <= '0;
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rx_data      = r_data;
    assign bus.rx_valid     = r_valid;
    assign bus.rx_frame_err = r_frame_err;
    assign bus.rx_busy      = r_busy;

endmodule
